// File: rtl/dist_collector.sv
// Collects one wavefront of PE results with a per-lane valid mask and streams
// the masked-valid lanes out, lowest lane first, tagged with lane id and last.
// Ports: clk/rst (sync, active-high); i_data_bus/i_valid_mask/i_valid/o_ready
// wavefront input; o_data/o_pe_id/o_last/o_valid/i_ready beat output;
// o_wave_cnt counts retired wavefronts, including empty-mask ones.
// Latency: first beat appears the cycle after acceptance, then one beat per
// cycle. Backpressure: o_ready drops while draining, except on the accepted
// last beat, so that a new wavefront can follow with no bubble.
module dist_collector #(
  parameter  int DATA_TYPE = 16,
  parameter  int NUM_PES   = 8,
  localparam int ID_W      = $clog2(NUM_PES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PES*DATA_TYPE-1:0]   i_data_bus,
  input  logic [NUM_PES-1:0]             i_valid_mask,
  input  logic                           i_valid,
  output logic                           o_ready,
  output logic [DATA_TYPE-1:0]           o_data,
  output logic [ID_W-1:0]                o_pe_id,
  output logic                           o_last,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [15:0]                    o_wave_cnt
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                         state_q, state_d;
  logic [NUM_PES*DATA_TYPE-1:0]   data_q, data_d;
  logic [NUM_PES-1:0]             mask_q, mask_d;
  logic [15:0]                    wave_cnt_q, wave_cnt_d;

  logic [ID_W-1:0]      sel_id;
  logic [DATA_TYPE-1:0] sel_data;
  logic                 one_left;
  logic                 accept;
  logic                 retire;
  logic [1:0]           cnt_inc;

  // Lowest set bit of the remaining mask; scanning downward lets the lowest
  // index win.
  always_comb begin
    sel_id   = '0;
    sel_data = '0;
    for (int k = NUM_PES - 1; k >= 0; k--) begin
      if (mask_q[k]) begin
        sel_id   = ID_W'(k);
        sel_data = data_q[k*DATA_TYPE +: DATA_TYPE];
      end
    end
  end

  // Exactly one bit left: nonzero and clearing the lowest bit leaves zero.
  assign one_left = (mask_q != '0) && ((mask_q & (mask_q - NUM_PES'(1))) == '0);

  // Outputs come only from registered state; forced to zero outside DRAIN.
  assign o_valid    = (state_q == DRAIN);
  assign o_data     = o_valid ? sel_data : '0;
  assign o_pe_id    = o_valid ? sel_id   : '0;
  assign o_last     = o_valid & one_left;
  assign o_wave_cnt = wave_cnt_q;

  assign o_ready = !rst && ((state_q == IDLE) || (o_last && i_ready));
  assign accept  = i_valid & o_ready;
  assign retire  = o_valid & i_ready;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    mask_d     = mask_q;
    cnt_inc    = 2'd0;

    if (retire) begin
      mask_d = mask_q & (mask_q - NUM_PES'(1));
      if (o_last) begin
        state_d = IDLE;
        cnt_inc = cnt_inc + 2'd1;
      end
    end

    // Accept can coincide with the final retire; the new wavefront overrides
    // the (now empty) mask. An empty-mask wavefront retires immediately.
    if (accept) begin
      if (i_valid_mask != '0) begin
        data_d  = i_data_bus;
        mask_d  = i_valid_mask;
        state_d = DRAIN;
      end else begin
        cnt_inc = cnt_inc + 2'd1;
      end
    end

    wave_cnt_d = wave_cnt_q + 16'(cnt_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      mask_q     <= '0;
      wave_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      wave_cnt_q <= wave_cnt_d;
    end
  end

endmodule

// File: tb/tb_dist_collector.sv
module tb_dist_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] i_data_bus;
  logic [7:0]   i_valid_mask;
  logic         i_valid;
  logic         o_ready;
  logic [15:0]  o_data;
  logic [2:0]   o_pe_id;
  logic         o_last;
  logic         o_valid;
  logic         i_ready;
  logic [15:0]  o_wave_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] DBUS = 128'h7777_6666_5555_4444_3333_2222_1111_0000;

  dist_collector #(.DATA_TYPE(16), .NUM_PES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_data_bus   (i_data_bus),
    .i_valid_mask (i_valid_mask),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_data       (o_data),
    .o_pe_id      (o_pe_id),
    .o_last       (o_last),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_wave_cnt   (o_wave_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int id, input logic [15:0] dat, input logic last);
    chk({tag, ".valid"}, 32'(o_valid), 32'd1);
    chk({tag, ".id"},    32'(o_pe_id), 32'(id));
    chk({tag, ".data"},  32'(o_data),  32'(dat));
    chk({tag, ".last"},  32'(o_last),  32'(last));
  endtask

  // Advance to just after the next rising edge; inputs are changed here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_data_bus = '0; i_valid_mask = '0;

    // Reset state
    cyc(); cyc();
    @(negedge clk);
    chk("rst.o_valid", 32'(o_valid), 32'd0);
    chk("rst.o_ready", 32'(o_ready), 32'd0);
    chk("rst.o_data",  32'(o_data), 32'd0);
    chk("rst.o_pe_id", 32'(o_pe_id), 32'd0);
    chk("rst.o_last",  32'(o_last), 32'd0);
    chk("rst.cnt",     32'(o_wave_cnt), 32'd0);
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("idle.o_ready", 32'(o_ready), 32'd1);

    // 1. Full mask, continuous ready
    cyc(); i_valid = 1'b1; i_data_bus = DBUS; i_valid_mask = 8'hFF; i_ready = 1'b1;
    @(negedge clk);
    chk("t1.o_ready", 32'(o_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k == 0) i_valid = 1'b0;
      @(negedge clk);
      chk_beat($sformatf("t1.beat%0d", k), k, 16'(k * 16'h1111), (k == 7));
    end
    cyc(); @(negedge clk);
    chk("t1.done.valid", 32'(o_valid), 32'd0);
    chk("t1.cnt",        32'(o_wave_cnt), 32'd1);

    // 2. Sparse mask, second wavefront accepted on the last beat
    cyc(); i_valid = 1'b1; i_valid_mask = 8'hA4;
    @(negedge clk);
    cyc(); i_valid = 1'b0;
    @(negedge clk);
    chk_beat("t2.b0", 2, 16'h2222, 1'b0);
    chk("t2.busy.o_ready", 32'(o_ready), 32'd0);
    cyc(); @(negedge clk);
    chk_beat("t2.b1", 5, 16'h5555, 1'b0);
    cyc(); i_valid = 1'b1; i_valid_mask = 8'h01;
    @(negedge clk);
    chk_beat("t2.b2", 7, 16'h7777, 1'b1);
    chk("t2.last.o_ready", 32'(o_ready), 32'd1);
    cyc(); i_valid = 1'b0;
    @(negedge clk);
    chk_beat("t2.w2", 0, 16'h0000, 1'b1);
    chk("t2.cnt.mid", 32'(o_wave_cnt), 32'd2);
    cyc(); @(negedge clk);
    chk("t2.done.valid", 32'(o_valid), 32'd0);
    chk("t2.cnt", 32'(o_wave_cnt), 32'd3);

    // 3. Backpressure on beat 0
    cyc(); i_valid = 1'b1; i_valid_mask = 8'h03; i_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (k == 0) i_valid = 1'b0;
      @(negedge clk);
      chk_beat($sformatf("t3.hold%0d", k), 0, 16'h0000, 1'b0);
      chk($sformatf("t3.hold%0d.o_ready", k), 32'(o_ready), 32'd0);
    end
    cyc(); i_ready = 1'b1;
    @(negedge clk);
    chk_beat("t3.b0", 0, 16'h0000, 1'b0);
    cyc(); @(negedge clk);
    chk_beat("t3.b1", 1, 16'h1111, 1'b1);
    cyc(); @(negedge clk);
    chk("t3.done.valid", 32'(o_valid), 32'd0);
    chk("t3.cnt", 32'(o_wave_cnt), 32'd4);

    // 4. Empty mask
    cyc(); i_valid = 1'b1; i_valid_mask = 8'h00;
    @(negedge clk);
    chk("t4.o_ready", 32'(o_ready), 32'd1);
    cyc(); i_valid = 1'b0;
    @(negedge clk);
    chk("t4.valid", 32'(o_valid), 32'd0);
    chk("t4.cnt", 32'(o_wave_cnt), 32'd5);
    chk("t4.o_ready.after", 32'(o_ready), 32'd1);

    // 5. Reset mid-drain
    cyc(); i_valid = 1'b1; i_valid_mask = 8'hFF;
    @(negedge clk);
    cyc(); i_valid = 1'b0;
    @(negedge clk);
    chk_beat("t5.b0", 0, 16'h0000, 1'b0);
    cyc(); @(negedge clk);
    chk_beat("t5.b1", 1, 16'h1111, 1'b0);
    cyc(); rst = 1'b1;
    @(negedge clk);
    chk("t5.rst.o_ready", 32'(o_ready), 32'd0);
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("t5.valid", 32'(o_valid), 32'd0);
    chk("t5.cnt", 32'(o_wave_cnt), 32'd0);
    cyc(); i_valid = 1'b1; i_valid_mask = 8'h10;
    @(negedge clk);
    cyc(); i_valid = 1'b0;
    @(negedge clk);
    chk_beat("t5.single", 4, 16'h4444, 1'b1);
    cyc(); @(negedge clk);
    chk("t5.done.valid", 32'(o_valid), 32'd0);
    chk("t5.cnt.after", 32'(o_wave_cnt), 32'd1);

    // i_valid=0 is ignored whatever the mask
    cyc(); i_valid = 1'b0; i_valid_mask = 8'hFF;
    @(negedge clk);
    cyc(); @(negedge clk);
    chk("ign.valid", 32'(o_valid), 32'd0);
    chk("ign.cnt", 32'(o_wave_cnt), 32'd1);

    // 6. Counter wrap
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; i_valid = 1'b1; i_valid_mask = 8'h00;
    repeat (65535) cyc();
    i_valid = 1'b0;
    @(negedge clk);
    chk("t6.cnt.max", 32'(o_wave_cnt), 32'h0000FFFF);
    cyc(); i_valid = 1'b1;
    @(negedge clk);
    cyc(); i_valid = 1'b0;
    @(negedge clk);
    chk("t6.cnt.wrap", 32'(o_wave_cnt), 32'd0);
    chk("t6.valid", 32'(o_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
